// File: rtl/pid_core_sat.sv
// Signed PID controller with one time-shared multiplier, programmable gains and setpoint,
// integrator clamp (anti-windup) and symmetric output saturation.
module pid_core_sat #(
  parameter int WIDTH     = 16,
  parameter int GAIN_W    = 16,
  parameter int ACC_W     = 48,
  parameter int FRAC_BITS = 0,
  parameter int INT_LIMIT = 1023,
  parameter int OUT_W     = 16,
  parameter int OUT_LIMIT = 32767,
  parameter int KP0       = 77,
  parameter int KI0       = 1,
  parameter int KD0       = 10,
  parameter int SETPOINT0 = 180
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_sample,
  input  logic [WIDTH-1:0]  setpoint,
  input  logic              gain_we,
  input  logic [GAIN_W-1:0] kp_in,
  input  logic [GAIN_W-1:0] ki_in,
  input  logic [GAIN_W-1:0] kd_in,
  input  logic              integ_clr,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_power,
  output logic              busy
);

  localparam int EW = WIDTH + 1;
  localparam logic signed [ACC_W-1:0] INT_LIM_S = ACC_W'(INT_LIMIT);
  localparam logic signed [ACC_W-1:0] OUT_LIM_S = ACC_W'(OUT_LIMIT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    MP   = 3'd2,
    MI   = 3'd3,
    MD   = 3'd4,
    SAT  = 3'd5
  } state_t;

  state_t stateCur_r, stateNext_s;

  logic                     inReady_r, busy_r, outValid_r;
  logic signed [OUT_W-1:0]  outPower_r;
  logic [GAIN_W-1:0]        kp_r, ki_r, kd_r;
  logic [GAIN_W-1:0]        wKp_r, wKi_r, wKd_r;
  logic signed [WIDTH-1:0]  wSample_r, wSetpoint_r, prev_r;
  logic signed [EW-1:0]     err_r, deriv_r, integ_r;
  logic                     first_r;
  logic signed [ACC_W-1:0]  acc_r;

  logic                     accept_s;
  logic signed [EW-1:0]     opA_s, errNew_s, derivNew_s;
  logic [GAIN_W-1:0]        opB_s;
  logic signed [ACC_W-1:0]  prod_s, integSum_s, shifted_s;

  // Symmetric clamp: the negative bound is -lim, never -lim-1.
  function automatic logic signed [ACC_W-1:0] clampSym(
    input logic signed [ACC_W-1:0] v,
    input logic signed [ACC_W-1:0] lim
  );
    logic signed [ACC_W-1:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign accept_s   = in_valid & inReady_r;
  assign errNew_s   = {wSample_r[WIDTH-1], wSample_r} - {wSetpoint_r[WIDTH-1], wSetpoint_r};
  assign derivNew_s = first_r ? {EW{1'b0}} : ({wSample_r[WIDTH-1], wSample_r} - {prev_r[WIDTH-1], prev_r});
  assign integSum_s = $signed({{(ACC_W-EW){integ_r[EW-1]}}, integ_r})
                    + $signed({{(ACC_W-EW){errNew_s[EW-1]}}, errNew_s});
  assign prod_s     = $signed({{(ACC_W-EW){opA_s[EW-1]}}, opA_s})
                    * $signed({{(ACC_W-GAIN_W){1'b0}}, opB_s});
  assign shifted_s  = acc_r >>> FRAC_BITS;

  assign in_ready  = inReady_r;
  assign busy      = busy_r;
  assign out_valid = outValid_r;
  assign out_power = outPower_r;

  // Next-state logic and multiplier operand selection.
  always_comb begin
    stateNext_s = stateCur_r;
    opA_s       = {EW{1'b0}};
    opB_s       = {GAIN_W{1'b0}};
    case (stateCur_r)
      IDLE: begin
        if (accept_s) begin
          stateNext_s = ERR;
        end else begin
          stateNext_s = IDLE;
        end
      end
      ERR: stateNext_s = MP;
      MP: begin
        stateNext_s = MI;
        opA_s       = err_r;
        opB_s       = wKp_r;
      end
      MI: begin
        stateNext_s = MD;
        opA_s       = integ_r;
        opB_s       = wKi_r;
      end
      MD: begin
        stateNext_s = SAT;
        opA_s       = deriv_r;
        opB_s       = wKd_r;
      end
      SAT:     stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // State register with registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateCur_r <= IDLE;
      inReady_r  <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      stateCur_r <= stateNext_s;
      inReady_r  <= (stateNext_s == IDLE);
      busy_r     <= (stateNext_s != IDLE);
    end
  end

  // Datapath: working copies, PID terms, accumulator and saturated output.
  always_ff @(posedge clk) begin
    if (rst) begin
      kp_r        <= GAIN_W'(KP0);
      ki_r        <= GAIN_W'(KI0);
      kd_r        <= GAIN_W'(KD0);
      wKp_r       <= GAIN_W'(KP0);
      wKi_r       <= GAIN_W'(KI0);
      wKd_r       <= GAIN_W'(KD0);
      wSample_r   <= {WIDTH{1'b0}};
      wSetpoint_r <= WIDTH'(SETPOINT0);
      prev_r      <= {WIDTH{1'b0}};
      err_r       <= {EW{1'b0}};
      deriv_r     <= {EW{1'b0}};
      integ_r     <= {EW{1'b0}};
      first_r     <= 1'b1;
      acc_r       <= {ACC_W{1'b0}};
      outValid_r  <= 1'b0;
      outPower_r  <= {OUT_W{1'b0}};
    end else begin
      outValid_r <= 1'b0;
      case (stateCur_r)
        IDLE: begin
          if (integ_clr) begin
            integ_r <= {EW{1'b0}};
            first_r <= 1'b1;
          end
          if (accept_s) begin
            wSample_r   <= in_sample;
            wSetpoint_r <= setpoint;
            wKp_r       <= kp_r;
            wKi_r       <= ki_r;
            wKd_r       <= kd_r;
          end
        end
        ERR: begin
          err_r   <= errNew_s;
          deriv_r <= derivNew_s;
          integ_r <= EW'(clampSym(integSum_s, INT_LIM_S));
          prev_r  <= wSample_r;
          first_r <= 1'b0;
        end
        MP: acc_r <= prod_s;
        MI: acc_r <= acc_r + prod_s;
        MD: acc_r <= acc_r + prod_s;
        SAT: begin
          outPower_r <= OUT_W'(clampSym(shifted_s, OUT_LIM_S));
          outValid_r <= 1'b1;
        end
        default: outValid_r <= 1'b0;
      endcase
      // Gains may change at any time; an in-flight sample keeps its working copy.
      if (gain_we) begin
        kp_r <= kp_in;
        ki_r <= ki_in;
        kd_r <= kd_in;
      end
    end
  end

endmodule

// File: tb/tb_pid_core_sat.sv
// Self-checking bench for pid_core_sat: directed cases plus randomized traffic,
// compared every cycle against a sample-level behavioural model.
module tb_pid_core_sat;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic [15:0] setpoint;
  logic        gain_we;
  logic [15:0] kp_in, ki_in, kd_in;
  logic        integ_clr;
  logic        out_valid;
  logic [15:0] out_power;
  logic        busy;

  int checks = 0;
  int failures = 0;

  pid_core_sat dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .setpoint(setpoint), .gain_we(gain_we),
    .kp_in(kp_in), .ki_in(ki_in), .kd_in(kd_in), .integ_clr(integ_clr),
    .out_valid(out_valid), .out_power(out_power), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint clampL(input longint v, input longint lim);
    if (v > lim) return lim;
    else if (v < -lim) return -lim;
    else return v;
  endfunction

  // Behavioural model: one whole sample is evaluated on acceptance, result released 5 edges later.
  longint mKp, mKi, mKd, mInteg, mPrev, mPend, expOut;
  bit     mFirst, expValid, expReady;
  int     mRem;

  initial begin
    bit armed;
    longint s, sp, err, der, acc;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (armed) begin
        check("in_ready", in_ready, expReady);
        check("busy", busy, !expReady);
        check("out_valid", out_valid, expValid);
        check("out_power", longint'($signed(out_power)), expOut);
      end
      armed = 1'b1;
      if (rst) begin
        mKp = 77; mKi = 1; mKd = 10; mInteg = 0; mPrev = 0; mFirst = 1'b1;
        mRem = 0; expValid = 1'b0; expOut = 0; expReady = 1'b1;
      end else begin
        expValid = 1'b0;
        if (mRem > 0) begin
          mRem--;
          if (mRem == 0) begin
            expValid = 1'b1;
            expOut = mPend;
          end
        end else begin
          if (integ_clr) begin
            mInteg = 0;
            mFirst = 1'b1;
          end
          if (in_valid) begin
            s = longint'($signed(in_sample));
            sp = longint'($signed(setpoint));
            err = s - sp;
            der = mFirst ? 0 : s - mPrev;
            mInteg = clampL(mInteg + err, 1023);
            mPrev = s;
            mFirst = 1'b0;
            acc = mKp * err + mKi * mInteg + mKd * der;
            mPend = clampL(acc, 32767);
            mRem = 5;
          end
        end
        if (gain_we) begin
          mKp = longint'(kp_in); mKi = longint'(ki_in); mKd = longint'(kd_in);
        end
        expReady = (mRem == 0);
      end
    end
  end

  task automatic sendSample(input int s, input int sp, input bit clr);
    bit ok;
    ok = 1'b0;
    in_sample = 16'(s);
    setpoint = 16'(sp);
    in_valid = 1'b1;
    integ_clr = clr;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    integ_clr = 1'b0;
    check("accept_bound", ok, 1);
  endtask

  task automatic waitOut(output int lat, output int val);
    bit got;
    got = 1'b0;
    lat = 0;
    val = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        got = 1'b1;
        val = int'($signed(out_power));
        break;
      end
    end
    check("out_valid_bound", got, 1);
  endtask

  task automatic setGains(input int kp, input int ki, input int kd);
    kp_in = 16'(kp); ki_in = 16'(ki); kd_in = 16'(kd);
    gain_we = 1'b1;
    @(posedge clk);
    #1;
    gain_we = 1'b0;
  endtask

  task automatic pulseClr();
    integ_clr = 1'b1;
    @(posedge clk);
    #1;
    integ_clr = 1'b0;
  endtask

  initial begin
    int lat, val, accN, vldN;
    rst = 1'b1; in_valid = 1'b0; in_sample = 16'd0; setpoint = 16'd0;
    gain_we = 1'b0; kp_in = 16'd0; ki_in = 16'd0; kd_in = 16'd0; integ_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_power", longint'($signed(out_power)), 0);
    rst = 1'b0;

    sendSample(200, 180, 1'b0);
    waitOut(lat, val);
    check("t1_latency", lat, 5);
    check("t1_value", val, 1560);

    sendSample(190, 180, 1'b0);
    waitOut(lat, val);
    check("t2_value", val, 700);

    setGains(0, 1, 0);
    pulseClr();
    sendSample(680, 180, 1'b0); waitOut(lat, val); check("t3_first", val, 500);
    sendSample(680, 180, 1'b0); waitOut(lat, val); check("t3_second", val, 1000);
    sendSample(680, 180, 1'b0); waitOut(lat, val); check("t3_clamp", val, 1023);

    setGains(1000, 1, 0);
    sendSample(280, 180, 1'b0); waitOut(lat, val); check("t4_pos_sat", val, 32767);
    sendSample(0, 180, 1'b1);   waitOut(lat, val); check("t4_neg_sat", val, -32767);

    accN = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (in_ready) accN++;
      @(posedge clk);
      #1;
      in_sample = 16'(int'($urandom_range(0, 400)) - 200);
    end
    in_valid = 1'b0;
    check("t5_accept_count", accN, 5);
    repeat (8) @(posedge clk);
    #1;

    setGains(77, 1, 10);
    pulseClr();
    sendSample(200, 180, 1'b0);
    @(posedge clk);
    #1;
    setGains(0, 0, 0);
    waitOut(lat, val);
    check("t5_gain_inflight", val, 1560);
    sendSample(200, 180, 1'b0); waitOut(lat, val); check("t5_gain_next", val, 0);

    sendSample(200, 180, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_out_power", longint'($signed(out_power)), 0);
    check("t6_in_ready", in_ready, 1);
    vldN = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) vldN++;
    end
    check("t6_no_pulse", vldN, 0);
    sendSample(200, 180, 1'b0); waitOut(lat, val); check("t6_first_after_rst", val, 1560);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_sample = 16'(int'($urandom_range(0, 8000)) - 4000);
      setpoint  = 16'(int'($urandom_range(0, 2000)) - 1000);
      integ_clr = ($urandom_range(0, 14) == 0);
      gain_we   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        kp_in = 16'($urandom_range(0, 3000));
        ki_in = 16'($urandom_range(0, 3000));
        kd_in = 16'($urandom_range(0, 3000));
      end else begin
        kp_in = 16'($urandom_range(0, 8));
        ki_in = 16'($urandom_range(0, 8));
        kd_in = 16'($urandom_range(0, 8));
      end
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; in_valid = 1'b0; gain_we = 1'b0; integ_clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
